data_memory_controller: RTL and testbench

DATA_MEMORY_CONTROLLER -- requirements
Module: data_memory_controller

---
 rtl/data_memory_controller.sv | 187 ++++++++++++++++++
 tb/tb_data_memory_controller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_controller.sv
// Data memory controller for the MEM stage.
// Turns a level load/store request into a sequenced RAM access. The pipeline
// stays stalled until the access completes. Sub-word stores are lane-replicated
// with byte enables. Loads are lane-selected and then sign- or zero-extended.
// Handshake: a request (memory_read/memory_write) is a level that the MEM stage
// holds until it sees stall low. The cycle in which stall drops is the final
// cycle of that instruction, so a request seen there is the same instruction
// and is ignored.
module data_memory_controller #(
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int RAM_LATENCY    = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      memory_read,
  input  logic                      memory_write,
  input  logic [2:0]                funct3,
  input  logic [31:0]               address,
  input  logic [31:0]               write_data,
  output logic [31:0]               read_data,
  output logic                      stall,
  output logic                      memory_fault,
  output logic [RAM_ADDR_WIDTH-1:0] ram_address,
  output logic                      ram_write_enable,
  output logic [3:0]                ram_byte_enable,
  output logic [31:0]               ram_write_data,
  input  logic [31:0]               ram_read_data,
  output logic [1:0]                o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ACCESS    = 2'd1,
    S_READ_WAIT = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_f3;
  logic        r_is_write;
  logic [2:0]  r_count;
  logic [31:0] r_read_data;

  logic        w_req;
  logic        w_fault_cond;
  logic        w_fault;
  logic        w_accept;
  logic [3:0]  w_be;
  logic [7:0]  w_lane_b;
  logic [15:0] w_lane_h;
  logic [31:0] w_load_ext;
  logic        w_unused_addr;

  assign w_req    = memory_read | memory_write;
  assign w_fault  = (r_state == S_IDLE) && w_req && w_fault_cond;
  assign w_accept = (r_state == S_IDLE) && w_req && !w_fault_cond;

  // Misalignment and illegal size codes, checked on the live request.
  always_comb begin
    w_fault_cond = 1'b0;
    case (funct3)
      3'b000, 3'b100: w_fault_cond = 1'b0;
      3'b001, 3'b101: w_fault_cond = address[0];
      3'b010:         w_fault_cond = (address[1:0] != 2'b00);
      default:        w_fault_cond = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state plus the stall and RAM write strobes.
  always_comb begin
    w_next           = r_state;
    stall            = 1'b0;
    ram_write_enable = 1'b0;
    ram_byte_enable  = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          stall  = 1'b1;
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        stall = 1'b1;
        if (r_is_write) begin
          ram_write_enable = 1'b1;
          ram_byte_enable  = w_be;
          w_next           = S_DONE;
        end else begin
          w_next = S_READ_WAIT;
        end
      end
      S_READ_WAIT: begin
        stall = 1'b1;
        if (r_count <= 3'd1) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, latency counter and load result register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_f3        <= '0;
      r_is_write  <= 1'b0;
      r_count     <= '0;
      r_read_data <= '0;
    end else begin
      if (w_accept) begin
        r_addr     <= address;
        r_wdata    <= write_data;
        r_f3       <= funct3;
        r_is_write <= memory_write;
      end
      if (r_state == S_ACCESS && !r_is_write)
        r_count <= 3'(RAM_LATENCY);
      else if (r_state == S_READ_WAIT && r_count != 3'd0)
        r_count <= r_count - 3'd1;
      if (w_fault)
        r_read_data <= '0;
      else if (r_state == S_READ_WAIT && r_count <= 3'd1)
        r_read_data <= w_load_ext;
    end
  end

  // Byte enables and lane-replicated store data for the registered size.
  always_comb begin
    w_be           = 4'b1111;
    ram_write_data = r_wdata;
    case (r_f3[1:0])
      2'b00: begin
        w_be           = 4'b0001 << r_addr[1:0];
        ram_write_data = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be           = 4'b0011 << {r_addr[1], 1'b0};
        ram_write_data = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be           = 4'b1111;
        ram_write_data = r_wdata;
      end
    endcase
  end

  // Lane select and extension of the returning RAM word.
  always_comb begin
    w_lane_b   = ram_read_data[7:0];
    w_lane_h   = ram_read_data[15:0];
    w_load_ext = ram_read_data;
    case (r_addr[1:0])
      2'b00: w_lane_b = ram_read_data[7:0];
      2'b01: w_lane_b = ram_read_data[15:8];
      2'b10: w_lane_b = ram_read_data[23:16];
      default: w_lane_b = ram_read_data[31:24];
    endcase
    if (r_addr[1]) w_lane_h = ram_read_data[31:16];
    case (r_f3)
      3'b000:  w_load_ext = {{24{w_lane_b[7]}}, w_lane_b};
      3'b001:  w_load_ext = {{16{w_lane_h[15]}}, w_lane_h};
      3'b100:  w_load_ext = {24'd0, w_lane_b};
      3'b101:  w_load_ext = {16'd0, w_lane_h};
      default: w_load_ext = ram_read_data;
    endcase
  end

  assign ram_address   = r_addr[RAM_ADDR_WIDTH+1:2];
  assign memory_fault  = w_fault;
  // A faulting cycle reports zero at once; the register is cleared on the edge.
  assign read_data     = w_fault ? 32'd0 : r_read_data;
  assign o_dbg_state   = r_state;
  assign w_unused_addr = &{1'b0, r_addr};

endmodule

// File: tb/tb_data_memory_controller.sv
// Bench for data_memory_controller: instance A uses RAM_LATENCY=1 and instance B
// uses RAM_LATENCY=3. Each instance has a behavioural RAM with matching latency.
// A byte-addressed model predicts every load result.
module tb_data_memory_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic ram_init;

  logic        a_rd, a_wr, b_rd, b_wr;
  logic [2:0]  a_f3, b_f3;
  logic [31:0] a_addr, a_wd, b_addr, b_wd;
  logic [31:0] a_rdata, b_rdata, a_rwd, b_rwd, a_rrd, b_rrd;
  logic        a_stall, b_stall, a_fault, b_fault, a_we, b_we;
  logic [9:0]  a_ra, b_ra;
  logic [3:0]  a_be, b_be;
  logic [1:0]  a_dbg, b_dbg;

  data_memory_controller #(.RAM_ADDR_WIDTH(10), .RAM_LATENCY(1)) dut_a (
    .clock(clock), .reset(reset), .memory_read(a_rd), .memory_write(a_wr),
    .funct3(a_f3), .address(a_addr), .write_data(a_wd), .read_data(a_rdata),
    .stall(a_stall), .memory_fault(a_fault), .ram_address(a_ra),
    .ram_write_enable(a_we), .ram_byte_enable(a_be), .ram_write_data(a_rwd),
    .ram_read_data(a_rrd), .o_dbg_state(a_dbg)
  );

  data_memory_controller #(.RAM_ADDR_WIDTH(10), .RAM_LATENCY(3)) dut_b (
    .clock(clock), .reset(reset), .memory_read(b_rd), .memory_write(b_wr),
    .funct3(b_f3), .address(b_addr), .write_data(b_wd), .read_data(b_rdata),
    .stall(b_stall), .memory_fault(b_fault), .ram_address(b_ra),
    .ram_write_enable(b_we), .ram_byte_enable(b_be), .ram_write_data(b_rwd),
    .ram_read_data(b_rrd), .o_dbg_state(b_dbg)
  );

  // Behavioural RAMs: A returns data one cycle after the address, B three.
  logic [31:0] ram_a [0:1023];
  logic [31:0] ram_b [0:1023];
  logic [31:0] b_p1, b_p2;

  always @(posedge clock) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) begin
        ram_a[i] <= 32'd0;
        ram_b[i] <= 32'd0;
      end
      ram_b[1] <= 32'hCAFE_F00D;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (a_we && a_be[i]) ram_a[a_ra][8*i +: 8] <= a_rwd[8*i +: 8];
        if (b_we && b_be[i]) ram_b[b_ra][8*i +: 8] <= b_rwd[8*i +: 8];
      end
    end
    a_rrd <= ram_a[a_ra];
    b_p1  <= ram_b[b_ra];
    b_p2  <= b_p1;
    b_rrd <= b_p2;
  end

  int cur = 0;
  logic        s_stall, s_fault, s_we;
  logic [3:0]  s_be;
  logic [9:0]  s_ra;
  logic [31:0] s_rwd, s_rdata;
  assign s_stall = (cur == 0) ? a_stall : b_stall;
  assign s_fault = (cur == 0) ? a_fault : b_fault;
  assign s_we    = (cur == 0) ? a_we    : b_we;
  assign s_be    = (cur == 0) ? a_be    : b_be;
  assign s_ra    = (cur == 0) ? a_ra    : b_ra;
  assign s_rwd   = (cur == 0) ? a_rwd   : b_rwd;
  assign s_rdata = (cur == 0) ? a_rdata : b_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  model_a [0:4095];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_store(input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] wd);
    int n;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) model_a[(addr + i) & 32'hFFF] = wd[8*i +: 8];
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [7:0]  b;
    logic [15:0] h;
    b = model_a[addr & 32'hFFF];
    h = {model_a[(addr + 1) & 32'hFFF], model_a[addr & 32'hFFF]};
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return {model_a[(addr + 3) & 32'hFFF], model_a[(addr + 2) & 32'hFFF], h};
    endcase
  endfunction

  // Drive one request on the selected instance and hold it until stall is low.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int n_stall, output int n_we, output int n_fault,
                       output int n_be_bad, output logic [3:0] be, output logic [9:0] ra,
                       output logic [31:0] wdat, output logic [31:0] rdat,
                       output logic [31:0] frdat);
    bit done;
    n_stall = 0; n_we = 0; n_fault = 0; n_be_bad = 0;
    be = 4'd0; ra = 10'd0; wdat = 32'd0; rdat = 32'hX; frdat = 32'hX;
    done = 1'b0;
    @(posedge clock); #1;
    if (cur == 0) begin a_rd = rd; a_wr = wr; a_f3 = f3; a_addr = addr; a_wd = wd; end
    else          begin b_rd = rd; b_wr = wr; b_f3 = f3; b_addr = addr; b_wd = wd; end
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clock);
      if (s_we) begin n_we++; be = s_be; ra = s_ra; wdat = s_rwd; end
      else if (s_be != 4'd0) n_be_bad++;
      if (s_fault) begin n_fault++; frdat = s_rdata; end
      if (s_stall) n_stall++;
      else begin done = 1'b1; rdat = s_rdata; end
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL op_timeout: observed=stall_stuck expected=stall_low");
    end
    @(posedge clock); #1;
    if (cur == 0) begin a_rd = 1'b0; a_wr = 1'b0; end
    else          begin b_rd = 1'b0; b_wr = 1'b0; end
  endtask

  int          n_stall, n_we, n_fault, n_be_bad;
  logic [3:0]  o_be;
  logic [9:0]  o_ra;
  logic [31:0] o_wdat, o_rdat, o_frdat;

  task automatic store_op(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
    model_store(f3, addr, wd);
    do_op(1'b0, 1'b1, f3, addr, wd, n_stall, n_we, n_fault, n_be_bad, o_be, o_ra,
          o_wdat, o_rdat, o_frdat);
    chk({tag, "_stall"}, 32'(n_stall), 32'd2);
    chk({tag, "_we"}, 32'(n_we), 32'd1);
    chk({tag, "_be_idle"}, 32'(n_be_bad), 32'd0);
  endtask

  task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input int exp_stall);
    exp_q.push_back(model_load(f3, addr));
    do_op(1'b1, 1'b0, f3, addr, 32'd0, n_stall, n_we, n_fault, n_be_bad, o_be, o_ra,
          o_wdat, o_rdat, o_frdat);
    chk({tag, "_stall"}, 32'(n_stall), 32'(exp_stall));
    chk({tag, "_we"}, 32'(n_we), 32'd0);
    chk({tag, "_data"}, o_rdat, exp_q.pop_front());
  endtask

  task automatic fault_op(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr);
    do_op(rd, wr, f3, addr, 32'hFFFF_FFFF, n_stall, n_we, n_fault, n_be_bad, o_be, o_ra,
          o_wdat, o_rdat, o_frdat);
    chk({tag, "_pulse"}, 32'(n_fault), 32'd1);
    chk({tag, "_stall"}, 32'(n_stall), 32'd0);
    chk({tag, "_we"}, 32'(n_we), 32'd0);
    chk({tag, "_rdata"}, o_frdat, 32'd0);
  endtask

  initial begin
    reset = 1'b1; ram_init = 1'b1;
    a_rd = 0; a_wr = 0; a_f3 = 0; a_addr = 0; a_wd = 0;
    b_rd = 0; b_wr = 0; b_f3 = 0; b_addr = 0; b_wd = 0;
    for (int i = 0; i < 4096; i++) model_a[i] = 8'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0; ram_init = 1'b0;
    @(negedge clock);
    chk("rst_state", {30'd0, a_dbg}, 32'd0);
    chk("rst_stall", {31'd0, a_stall}, 32'd0);
    chk("rst_fault", {31'd0, a_fault}, 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_we", {31'd0, a_we}, 32'd0);
    chk("rst_be", {28'd0, a_be}, 32'd0);
    chk("rst_ra", {22'd0, a_ra}, 32'd0);
    chk("rst_rwd", a_rwd, 32'd0);

    cur = 0;
    store_op("sw8", 3'b010, 32'h8, 32'hDEAD_BEEF);
    chk("sw8_be", {28'd0, o_be}, 32'hF);
    chk("sw8_ra", {22'd0, o_ra}, 32'd2);
    chk("sw8_wd", o_wdat, 32'hDEAD_BEEF);

    store_op("sb3", 3'b000, 32'h3, 32'h0000_00A5);
    chk("sb3_be", {28'd0, o_be}, 32'h8);
    chk("sb3_wd", o_wdat, 32'hA5A5_A5A5);

    store_op("sh0", 3'b001, 32'h0, 32'h0000_8000);
    chk("sh0_be", {28'd0, o_be}, 32'h3);

    load_op("lb1", 3'b000, 32'h1, 3);
    chk("lb1_vec", o_rdat, 32'hFFFF_FF80);
    load_op("lbu1", 3'b100, 32'h1, 3);
    chk("lbu1_vec", o_rdat, 32'h0000_0080);
    load_op("lw8", 3'b010, 32'h8, 3);

    fault_op("lw2", 1'b1, 1'b0, 3'b010, 32'h2);
    @(negedge clock);
    chk("lw2_rdata_after", a_rdata, 32'd0);
    fault_op("f3_011", 1'b1, 1'b0, 3'b011, 32'h0);
    fault_op("f3_110", 1'b1, 1'b0, 3'b110, 32'h4);
    fault_op("sh_odd", 1'b0, 1'b1, 3'b001, 32'h1);

    // Read and write together: the write is performed.
    model_store(3'b010, 32'h10, 32'h1122_3344);
    do_op(1'b1, 1'b1, 3'b010, 32'h10, 32'h1122_3344, n_stall, n_we, n_fault, n_be_bad,
          o_be, o_ra, o_wdat, o_rdat, o_frdat);
    chk("rw_stall", 32'(n_stall), 32'd2);
    chk("rw_we", 32'(n_we), 32'd1);
    load_op("rw_lw", 3'b010, 32'h10, 3);

    store_op("sh22", 3'b001, 32'h22, 32'h0000_9ABC);
    chk("sh22_be", {28'd0, o_be}, 32'hC);
    load_op("lh22", 3'b001, 32'h22, 3);
    chk("lh22_vec", o_rdat, 32'hFFFF_9ABC);
    load_op("lhu22", 3'b101, 32'h22, 3);
    chk("lhu22_vec", o_rdat, 32'h0000_9ABC);

    for (int k = 0; k < 16; k++) begin
      int          sz;
      logic [2:0]  f3;
      logic [31:0] ad;
      sz = int'($urandom_range(0, 2));
      ad = 32'($urandom_range(64, 79)) * 4;
      if (sz == 0) ad = ad + 32'($urandom_range(0, 3));
      else if (sz == 1) ad = ad + 32'($urandom_range(0, 1)) * 2;
      if ($urandom_range(0, 1) == 1) begin
        f3 = {1'b0, 2'(sz)};
        store_op("rnd_st", f3, ad, $urandom);
      end else begin
        f3 = (sz == 2) ? 3'b010 : {1'($urandom_range(0, 1)), 2'(sz)};
        load_op("rnd_ld", f3, ad, 3);
      end
    end

    // Instance B: three-cycle RAM.
    cur = 1;
    exp_q.push_back(32'hCAFE_F00D);
    do_op(1'b1, 1'b0, 3'b010, 32'h4, 32'd0, n_stall, n_we, n_fault, n_be_bad, o_be, o_ra,
          o_wdat, o_rdat, o_frdat);
    chk("b_lw_stall", 32'(n_stall), 32'd5);
    chk("b_lw_data", o_rdat, exp_q.pop_front());

    // Reset while the load sits in READ_WAIT.
    @(posedge clock); #1;
    b_rd = 1'b1; b_f3 = 3'b010; b_addr = 32'h4;
    @(posedge clock);
    @(posedge clock); #1;
    chk("b_in_rw", {30'd0, b_dbg}, 32'd2);
    reset = 1'b1; b_rd = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("b_rst_state", {30'd0, b_dbg}, 32'd0);
    chk("b_rst_stall", {31'd0, b_stall}, 32'd0);
    chk("b_rst_rdata", b_rdata, 32'd0);
    chk("b_rst_we", {31'd0, b_we}, 32'd0);
    chk("b_rst_be", {28'd0, b_be}, 32'd0);
    chk("b_rst_ra", {22'd0, b_ra}, 32'd0);
    chk("b_rst_rwd", b_rwd, 32'd0);

    do_op(1'b0, 1'b1, 3'b001, 32'h2, 32'h0000_1234, n_stall, n_we, n_fault, n_be_bad,
          o_be, o_ra, o_wdat, o_rdat, o_frdat);
    chk("b_sh_stall", 32'(n_stall), 32'd2);
    chk("b_sh_we", 32'(n_we), 32'd1);
    chk("b_sh_be", {28'd0, o_be}, 32'hC);
    chk("b_sh_wd", o_wdat, 32'h1234_1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
